hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It drives the stall/flush controls of the PC register, the IF/ID and ID/EX pipeline registers and the EX stage, and resolves three events:
- load-use data hazards, detected in ID;
- taken branches and jumps, redirected from EX;
- fixed-latency multi-cycle multiply/divide operations that occupy EX.

It also keeps stall and flush performance counters.

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage core.
// Resolves load-use hazards detected in ID, taken branches/jumps redirected
// from EX, and fixed-latency mul/div ops that occupy EX for MD_LAT cycles.
// Also keeps stall and flush performance counters.
//
// Ports:
//   clk, reset (async, active-low)
//   id_rs1/id_rs2/id_use_rs1/id_use_rs2/id_bubble : ID instruction operand info
//   ex_rd/ex_memread                              : EX instruction (load) info
//   ex_redirect/ex_target                         : taken branch/jump from EX
//   md_start                                      : mul/div op entering EX
//   pc_stop/pc_sel/pc_target                      : PC register control
//   ifid_stop/ifid_jump                           : IF/ID register control
//   idex_flush                                    : ID/EX bubble insert
//   ex_hold                                       : hold ID/EX + EX operands
//   md_busy                                       : mul/div wait in progress
//   stall_cnt/flush_cnt                           : performance counters
//
// state   | meaning
// --------+--------------------------------------------------------------
// RUN     | normal flow; load-use, redirect and md_start are evaluated
// MD_WAIT | mul/div still occupying EX; pipeline fully held

module hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_bubble,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        md_start,
  output logic        pc_stop,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        ifid_stop,
  output logic        ifid_jump,
  output logic        idex_flush,
  output logic        ex_hold,
  output logic        md_busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic pc_stop_c, pc_sel_c, ifid_stop_c, ifid_jump_c, idex_flush_c, ex_hold_c;
  logic redirect_fire;

  assign lu = (state_q == RUN) & ex_memread & (ex_rd != 5'd0) & ~id_bubble &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    pc_stop_c     = 1'b0;
    pc_sel_c      = 1'b0;
    ifid_stop_c   = 1'b0;
    ifid_jump_c   = 1'b0;
    idex_flush_c  = 1'b0;
    ex_hold_c     = 1'b0;
    redirect_fire = 1'b0;

    if (state_q == MD_WAIT) begin
      pc_stop_c   = 1'b1;
      ifid_stop_c = 1'b1;
      ex_hold_c   = 1'b1;
      md_cnt_d    = md_cnt_q - 8'd1;
      if (md_cnt_q == 8'd1) begin
        state_d = RUN;
      end
    end else if (md_start) begin
      // md_start beats a simultaneous redirect; that combination is illegal upstream.
      pc_stop_c   = 1'b1;
      ifid_stop_c = 1'b1;
      ex_hold_c   = 1'b1;
      if (MD_LAT > 1) begin
        state_d  = MD_WAIT;
        md_cnt_d = 8'(MD_LAT - 1);
      end
    end else if (ex_redirect) begin
      pc_sel_c      = 1'b1;
      ifid_jump_c   = 1'b1;
      idex_flush_c  = 1'b1;
      redirect_fire = 1'b1;
    end else if (lu) begin
      pc_stop_c    = 1'b1;
      ifid_stop_c  = 1'b1;
      idex_flush_c = 1'b1;
    end

    stall_cnt_d = stall_cnt_q + {31'd0, pc_stop_c};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect_fire};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are combinational, so they are gated by reset to stay quiet
  // while reset is asserted regardless of what the pipeline drives.
  assign pc_stop    = reset & pc_stop_c;
  assign pc_sel     = reset & pc_sel_c;
  assign ifid_stop  = reset & ifid_stop_c;
  assign ifid_jump  = reset & ifid_jump_c;
  assign idex_flush = reset & idex_flush_c;
  assign ex_hold    = reset & ex_hold_c;
  assign md_busy    = reset & (state_q == MD_WAIT);
  assign pc_target  = reset ? ex_target : 32'd0;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MD_LAT=4.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, id_bubble, ex_memread, ex_redirect, md_start;
  logic [31:0] ex_target;
  logic        pc_stop, pc_sel, ifid_stop, ifid_jump, idex_flush, ex_hold, md_busy;
  logic [31:0] pc_target, stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_bubble(id_bubble), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .md_start(md_start),
    .pc_stop(pc_stop), .pc_sel(pc_sel), .pc_target(pc_target),
    .ifid_stop(ifid_stop), .ifid_jump(ifid_jump), .idex_flush(idex_flush),
    .ex_hold(ex_hold), .md_busy(md_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_bubble = 1'b0; ex_rd = 5'd0; ex_memread = 1'b0;
    ex_redirect = 1'b0; ex_target = 32'd0; md_start = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_memread = 1'b1; ex_rd = rd; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
  endtask

  initial begin
    clear_in();
    reset = 1'b0;
    ex_redirect = 1'b1; ex_target = 32'hDEAD_BEEF;
    #12;
    chk("rst_pc_sel", {31'd0, pc_sel}, 32'd0);
    chk("rst_pc_target", pc_target, 32'd0);
    chk("rst_idex_flush", {31'd0, idex_flush}, 32'd0);
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    clear_in();
    reset = 1'b1;
    tick();

    chk("idle_pc_stop", {31'd0, pc_stop}, 32'd0);
    chk("idle_ex_hold", {31'd0, ex_hold}, 32'd0);

    // load-use on rs1
    set_lu(5'd5);
    #1;
    chk("lu_pc_stop", {31'd0, pc_stop}, 32'd1);
    chk("lu_ifid_stop", {31'd0, ifid_stop}, 32'd1);
    chk("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    chk("lu_ex_hold", {31'd0, ex_hold}, 32'd0);
    chk("lu_pc_sel", {31'd0, pc_sel}, 32'd0);
    tick();
    clear_in();
    #1;
    chk("lu_clear_pc_stop", {31'd0, pc_stop}, 32'd0);
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    // ex_rd == 0: no hazard
    ex_memread = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_rs1 = 5'd0;
    #1;
    chk("rd0_pc_stop", {31'd0, pc_stop}, 32'd0);
    tick(); clear_in();

    // bubble in ID: no hazard
    set_lu(5'd5); id_bubble = 1'b1;
    #1;
    chk("bubble_pc_stop", {31'd0, pc_stop}, 32'd0);
    tick(); clear_in();

    // rs1 not read: no hazard
    set_lu(5'd5); id_use_rs1 = 1'b0;
    #1;
    chk("nouse_pc_stop", {31'd0, pc_stop}, 32'd0);
    tick(); clear_in();

    // not a load: no hazard
    set_lu(5'd5); ex_memread = 1'b0;
    #1;
    chk("noload_pc_stop", {31'd0, pc_stop}, 32'd0);
    tick(); clear_in();

    // hazard through rs2
    ex_memread = 1'b1; ex_rd = 5'd17; id_use_rs2 = 1'b1; id_rs2 = 5'd17; id_rs1 = 5'd17;
    #1;
    chk("lu_rs2_idex_flush", {31'd0, idex_flush}, 32'd1);
    tick(); clear_in();
    #1;
    chk("lu_rs2_stall_cnt", stall_cnt, 32'd2);

    // redirect
    ex_redirect = 1'b1; ex_target = 32'h0000_0100;
    #1;
    chk("rd_pc_sel", {31'd0, pc_sel}, 32'd1);
    chk("rd_pc_target", pc_target, 32'h100);
    chk("rd_ifid_jump", {31'd0, ifid_jump}, 32'd1);
    chk("rd_idex_flush", {31'd0, idex_flush}, 32'd1);
    chk("rd_pc_stop", {31'd0, pc_stop}, 32'd0);
    chk("rd_ifid_stop", {31'd0, ifid_stop}, 32'd0);
    tick();
    ex_redirect = 1'b0; ex_target = 32'h0000_0240;
    #1;
    chk("rd_flush_cnt", flush_cnt, 32'd1);
    chk("nord_pc_sel", {31'd0, pc_sel}, 32'd0);
    chk("nord_pc_target", pc_target, 32'h240);
    clear_in();

    // lu and redirect together: redirect wins
    set_lu(5'd5); ex_redirect = 1'b1; ex_target = 32'h0000_0800;
    #1;
    chk("lurd_pc_stop", {31'd0, pc_stop}, 32'd0);
    chk("lurd_pc_sel", {31'd0, pc_sel}, 32'd1);
    chk("lurd_ifid_jump", {31'd0, ifid_jump}, 32'd1);
    tick(); clear_in();
    #1;
    chk("lurd_stall_cnt", stall_cnt, 32'd2);
    chk("lurd_flush_cnt", flush_cnt, 32'd2);

    // mul/div, cycle T
    md_start = 1'b1;
    #1;
    chk("md_T_ex_hold", {31'd0, ex_hold}, 32'd1);
    chk("md_T_pc_stop", {31'd0, pc_stop}, 32'd1);
    chk("md_T_md_busy", {31'd0, md_busy}, 32'd0);
    tick();
    // T+1: redirect and lu ignored
    md_start = 1'b0; set_lu(5'd5); ex_redirect = 1'b1; ex_target = 32'h0000_0400;
    #1;
    chk("md_T1_ex_hold", {31'd0, ex_hold}, 32'd1);
    chk("md_T1_md_busy", {31'd0, md_busy}, 32'd1);
    chk("md_T1_pc_sel", {31'd0, pc_sel}, 32'd0);
    chk("md_T1_idex_flush", {31'd0, idex_flush}, 32'd0);
    chk("md_T1_ifid_jump", {31'd0, ifid_jump}, 32'd0);
    tick();
    // T+2: md_start ignored while busy
    md_start = 1'b1;
    #1;
    chk("md_T2_ex_hold", {31'd0, ex_hold}, 32'd1);
    tick();
    md_start = 1'b0;
    #1;
    chk("md_T3_ex_hold", {31'd0, ex_hold}, 32'd1);
    chk("md_T3_md_busy", {31'd0, md_busy}, 32'd1);
    tick();
    clear_in();
    #1;
    chk("md_T4_ex_hold", {31'd0, ex_hold}, 32'd0);
    chk("md_T4_md_busy", {31'd0, md_busy}, 32'd0);
    chk("md_stall_cnt", stall_cnt, 32'd6);
    chk("md_flush_cnt", flush_cnt, 32'd2);

    // illegal md_start + redirect: md_start wins
    md_start = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0900;
    #1;
    $display("note: md_start with ex_redirect applied (illegal combination)");
    chk("mdrd_pc_sel", {31'd0, pc_sel}, 32'd0);
    chk("mdrd_ex_hold", {31'd0, ex_hold}, 32'd1);
    tick(); clear_in();
    tick(); tick(); tick();
    #1;
    chk("mdrd_ex_hold_end", {31'd0, ex_hold}, 32'd0);
    chk("mdrd_stall_cnt", stall_cnt, 32'd10);
    chk("mdrd_flush_cnt", flush_cnt, 32'd2);

    // reset at T+2 of a mul/div sequence
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    tick();
    chk("mdrst_T2_md_busy", {31'd0, md_busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mdrst_ex_hold", {31'd0, ex_hold}, 32'd0);
    chk("mdrst_pc_stop", {31'd0, pc_stop}, 32'd0);
    chk("mdrst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("mdrst_stall_cnt", stall_cnt, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_ex_hold", {31'd0, ex_hold}, 32'd0);
    chk("post_rst_md_busy", {31'd0, md_busy}, 32'd0);
    tick();
    chk("post_rst2_ex_hold", {31'd0, ex_hold}, 32'd0);
    chk("post_rst2_stall_cnt", stall_cnt, 32'd0);
    // normal operation resumes
    set_lu(5'd5);
    #1;
    chk("post_rst_lu", {31'd0, pc_stop}, 32'd1);
    tick(); clear_in();
    #1;
    chk("post_rst_stall_cnt", stall_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
